ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, 10, RAM address width (1024 locations).
REQ-002 The block SHALL have parameter DATA_W, 8, RAM data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 The block SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  ADDR_W  request address.
REQ-009 The block SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 The block SHALL have port rsp_valid  output  1  read data available.
REQ-011 The block SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-012 The block SHALL have port rsp_data  output  DATA_W  read data.
REQ-013 The block SHALL have port rsp_addr  output  ADDR_W  address the read data came from.
REQ-014 The block SHALL have port ram_cs  output  1  RAM chip select.
REQ-015 The block SHALL have port ram_we  output  1  RAM write enable (1 write, 0 read).
REQ-016 The block SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-017 The block SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-018 The block SHALL have port ram_rdata  input  DATA_W  RAM read data, valid one cycle after the read access cycle.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, RDWAIT and RESP, plus INIT when the feature in Configuration is compiled in.
REQ-020 IDLE: req_ready = 1; handshake = req_valid && req_ready; on handshake, register write, addr and wdata, then go to ACCESS.
REQ-021 ACCESS lasts exactly one cycle: ram_cs = 1, ram_we = the registered write bit, and ram_addr/ram_wdata come from registers; a write goes to IDLE, a read goes to RDWAIT.
REQ-022 RDWAIT lasts one cycle: capture ram_rdata into rsp_data and the registered address into rsp_addr, then go to RESP.
REQ-023 RESP: rsp_valid = 1 with rsp_data/rsp_addr stable; on rsp_ready go to IDLE, otherwise hold indefinitely (backpressure).
REQ-024 req_ready SHALL be 0 in every state except IDLE; requests presented then SHALL be ignored, not lost, because the requester holds them.
REQ-025 Latency: write, handshake to RAM write = 1 cycle, throughput 1 per 2 cycles; read, handshake to rsp_valid = 3 cycles.
REQ-026 Outside ACCESS (and INIT), ram_cs and ram_we SHALL be 0; ram_addr/ram_wdata hold their last value.
REQ-027 rsp_valid SHALL be 0 in all states except RESP; rsp_ready outside RESP SHALL be ignored.
REQ-028 Address range 0 through 2^ADDR_W-1 is fully usable with no wrap or clipping; addr 0x3FF behaves like any other address.

Reset
REQ-029 When rst = 1 at a clock edge: state = IDLE (or INIT), req_ready = 0 that cycle, rsp_valid = 0, ram_cs = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rsp_data = 0, rsp_addr = 0.
REQ-030 Reset asserted mid-operation (ACCESS, RDWAIT, RESP) SHALL abort the operation with no RAM access and no response issued.

Configuration
REQ-031 Macro RAM_CTRL_INIT_EN defined: after reset, go to INIT, which writes 0 to every address 0..2^ADDR_W-1, one per cycle (ram_cs = ram_we = 1, ram_wdata = 0), with req_ready = 0; go to IDLE after the last address.
REQ-032 RAM_CTRL_INIT_EN undefined: no INIT state; reset goes directly to IDLE; RAM contents are untouched.

Structure
REQ-033 Package ram_ctrl_pkg SHALL hold the state enum typedef and the default ADDR_W/DATA_W constants.
REQ-034 One sub-module, ram_ctrl_init (address sweep counter plus done flag), SHALL be instantiated only under RAM_CTRL_INIT_EN.

Verification
REQ-035 Write addr 0x155 data 0xA5, then read 0x155 -> rsp_valid 3 cycles after the read handshake, rsp_data 0xA5, rsp_addr 0x155.
REQ-036 Read 0x3FF after writing 0x3C there with rsp_ready held 0 for 5 cycles -> rsp_valid and data stay stable for 5 cycles; one response; then IDLE.
REQ-037 req_valid held high for 10 back-to-back writes -> req_ready toggles 1/0, exactly 10 single-cycle ram_cs pulses with matching addresses.
REQ-038 rst asserted in RDWAIT of a read to 0x010 -> rsp_valid never asserts; all outputs 0 the next cycle.
REQ-039 With RAM_CTRL_INIT_EN: after reset, req_ready = 0 for 1024 cycles; then a read of random address 0x2B7 -> rsp_data 0x00.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizing for the single-port RAM request/response controller.
// The INIT state only exists when RAM_CTRL_INIT_EN is defined.
package ram_ctrl_pkg;

    localparam int unsigned RAM_CTRL_ADDR_W = 10;
    localparam int unsigned RAM_CTRL_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RDWAIT,
        ST_RESP
`ifdef RAM_CTRL_INIT_EN
        ,
        ST_INIT
`endif
    } state_e;

endpackage

// File: rtl/ram_ctrl_init.sv
// Post-reset clearing sweep: walks every RAM address once, flagging the last one.
// Compiled only when RAM_CTRL_INIT_EN is defined.
`ifdef RAM_CTRL_INIT_EN
module ram_ctrl_init
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_CTRL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cnt_q;
    // done marks the cycle in which the final address is being written
    assign done_o = en_i && (&cnt_q);

endmodule
`endif

// File: rtl/ram_ctrl.sv
// Request/response front end for a synchronous single-port RAM with one-cycle read latency.
// Define RAM_CTRL_INIT_EN to zero-fill the whole RAM after every reset before accepting requests.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_CTRL_ADDR_W,
    parameter int unsigned DATA_W = RAM_CTRL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

`ifdef RAM_CTRL_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              handshake;

`ifdef RAM_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_addr;
    logic              init_done;

    ram_ctrl_init #(
        .ADDR_W(ADDR_W)
    ) u_init (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_INIT),
        .addr_o (init_addr),
        .done_o (init_done)
    );
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_cs  = 1'b1;
                ram_we  = write_q;
                state_d = write_q ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef RAM_CTRL_INIT_EN
            ST_INIT: begin
                ram_cs    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = init_addr;
                ram_wdata = '0;
                if (init_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Reset gates the strobes combinationally so an aborted access never reaches the RAM
        if (rst) begin
            req_ready = 1'b0;
            ram_cs    = 1'b0;
            ram_we    = 1'b0;
        end
    end

    assign handshake = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_RDWAIT) begin
                rsp_data_q <= ram_rdata;
                rsp_addr_q <= addr_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_addr = rsp_addr_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl with a behavioural synchronous RAM attached.
// Covers the RAM_CTRL_INIT_EN sweep when that macro is defined for the build.
module tb_ram_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cs_cnt   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
    end

    always @(posedge clk) begin
        if (ram_cs === 1'b1) begin
            cs_cnt++;
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // After reset release: immediately ready, or ready only once the sweep is done
    task automatic wait_ready();
`ifdef RAM_CTRL_INIT_EN
        int n;
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            if (req_ready) break;
            n++;
            cyc();
        end
        chk("init_busy_cycles", n, 1024);
        chk("init_ready", req_ready, 1);
`else
        chk("ready_after_rst", req_ready, 1);
`endif
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        chk("wr_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("wr_cs", ram_cs, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, a);
        chk("wr_data", ram_wdata, d);
        chk("wr_busy", req_ready, 0);
        cyc();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'hC3;
        chk("rd_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("rd_cs", ram_cs, 1);
        chk("rd_we", ram_we, 0);
        chk("rd_addr", ram_addr, a);
        chk("rd_early_valid", rsp_valid, 0);
        cyc();
        chk("rdwait_cs", ram_cs, 0);
        chk("rdwait_valid", rsp_valid, 0);
        cyc();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp);
        chk("rsp_addr", rsp_addr, a);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h2AA; req_wdata = 8'h99;
            cyc();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, exp);
            chk("stall_addr", rsp_addr, a);
            chk("stall_ready", req_ready, 0);
            chk("stall_cs", ram_cs, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("back_idle", req_ready, 1);
    endtask

    initial begin
        int cs0;
        logic [DW-1:0] exp_020;
        logic [DW-1:0] exp_2b7;
`ifdef RAM_CTRL_INIT_EN
        exp_020 = 8'h00;
        exp_2b7 = 8'h00;
`else
        exp_020 = 8'h7A;
        exp_2b7 = 8'hED;
`endif
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        rst = 1'b0;
        #1;
        wait_ready();

        do_write(10'h155, 8'hA5);
        do_read(10'h155, 8'hA5, 0);
        do_write(10'h3FF, 8'h3C);
        do_read(10'h3FF, 8'h3C, 5);
        do_write(10'h000, 8'hFF);
        do_read(10'h000, 8'hFF, 0);
        do_read(10'h3FF, 8'h3C, 0);

        cs0 = cs_cnt;
        req_valid = 1'b1; req_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_addr = 10'(32'h100 + i);
            req_wdata = 8'(i * 3);
            chk("b2b_ready_hi", req_ready, 1);
            cyc();
            chk("b2b_cs", ram_cs, 1);
            chk("b2b_addr", ram_addr, 32'h100 + i);
            chk("b2b_data", ram_wdata, 8'(i * 3));
            chk("b2b_ready_lo", req_ready, 0);
            if (i == 9) req_valid = 1'b0;
            cyc();
        end
        chk("b2b_cs_pulses", cs_cnt - cs0, 10);
        do_read(10'h100, 8'h00, 0);
        do_read(10'h109, 8'h1B, 0);

        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010;
        chk("abort_rd_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_rd_cs", ram_cs, 0);
        cyc();
        chk("abort_rd_valid", rsp_valid, 0);
        chk("abort_rd_ready0", req_ready, 0);
        chk("abort_rd_ramcs", ram_cs, 0);
        chk("abort_rd_ramwe", ram_we, 0);
        chk("abort_rd_ramaddr", ram_addr, 0);
        chk("abort_rd_ramwdata", ram_wdata, 0);
        chk("abort_rd_rspdata", rsp_data, 0);
        chk("abort_rd_rspaddr", rsp_addr, 0);
        rst = 1'b0;
        #1;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_rd_no_rsp", rsp_valid, 0);
        end

        cs0 = cs_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 8'h77;
        chk("abort_wr_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_wr_cs", ram_cs, 0);
        chk("abort_wr_we", ram_we, 0);
        cyc();
        rst = 1'b0;
        chk("abort_wr_no_access", cs_cnt - cs0, 0);
        #1;
        wait_ready();
        do_read(10'h020, exp_020, 0);
        do_read(10'h2B7, exp_2b7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
